// File: rtl/lmsm_engine.sv
// ============================================================================
// lmsm_engine : load/store-multiple sequencer, one memory access per mask bit.
// Optional base-register write-back: define LMSM_BASE_WB_EN.      Rev 1.0
// ============================================================================
`default_nettype none

module lmsm_engine #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int NREGS     = 8,
  parameter int ADDR_STEP = 1,
  localparam int IDX_W    = $clog2(NREGS),
  localparam int CNT_W    = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREGS-1:0]  mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [IDX_W-1:0]  base_reg,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  xfer_count,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [IDX_W-1:0]  rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              rf_wen,
  output logic [IDX_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [NREGS-1:0]   rem_q, rem_d;
  logic [ADDR_W-1:0]  ptr_q, ptr_d;
  logic               store_q, store_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   cur;
  logic [NREGS-1:0]   rem_next;
  state_e             last_state;

`ifdef LMSM_BASE_WB_EN
  logic [IDX_W-1:0]   base_reg_q, base_reg_d;
  logic [DATA_W-1:0]  wb_data;

  // Final pointer is zero-extended or truncated to the register width.
  if (DATA_W > ADDR_W) begin : g_wb_zext
    assign wb_data = {{(DATA_W - ADDR_W){1'b0}}, ptr_q};
  end else if (DATA_W == ADDR_W) begin : g_wb_same
    assign wb_data = ptr_q;
  end else begin : g_wb_trunc
    assign wb_data = ptr_q[DATA_W-1:0];
  end

  assign last_state = S_WB;
`else
  logic unused_base_reg;
  assign unused_base_reg = ^base_reg;
  assign last_state      = S_DONE;
`endif

  // Lowest set bit of the remaining mask selects the current register.
  always_comb begin
    cur = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (rem_q[i]) cur = IDX_W'(i);
    end
  end

  assign rem_next   = rem_q & (rem_q - {{(NREGS-1){1'b0}}, 1'b1});
  assign xfer_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    ptr_d     = ptr_q;
    store_d   = store_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = '0;
    rf_raddr  = '0;
    rf_wen    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
`ifdef LMSM_BASE_WB_EN
    base_reg_d = base_reg_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_d   = mask;
          ptr_d   = base_addr;
          store_d = is_store;
          cnt_d   = '0;
`ifdef LMSM_BASE_WB_EN
          base_reg_d = base_reg;
`endif
          state_d = (mask != '0) ? S_ACCESS : last_state;
        end
      end
      S_ACCESS: begin
        busy     = 1'b1;
        mem_addr = ptr_q;
        rf_raddr = cur;
        if (store_q) begin
          mem_wr    = 1'b1;
          mem_wdata = rf_rdata;
        end else begin
          mem_rd = 1'b1;
        end
        if (mem_ready) begin
          if (!store_q) begin
            rf_wen   = 1'b1;
            rf_waddr = cur;
            rf_wdata = mem_rdata;
          end
          rem_d = rem_next;
          ptr_d = ptr_q + ADDR_W'(ADDR_STEP);
          cnt_d = cnt_q + CNT_W'(1);
          if (rem_next == '0) state_d = last_state;
        end
      end
`ifdef LMSM_BASE_WB_EN
      S_WB: begin
        busy     = 1'b1;
        rf_wen   = 1'b1;
        rf_waddr = base_reg_q;
        rf_wdata = wb_data;
        state_d  = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      ptr_q   <= '0;
      store_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      ptr_q   <= ptr_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef LMSM_BASE_WB_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) base_reg_q <= '0;
    else          base_reg_q <= base_reg_d;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lmsm_engine.sv
// Scoreboard bench for lmsm_engine: directed corner cases plus randomized transfers.
`default_nettype none

module tb_lmsm_engine;

`ifdef LMSM_BASE_WB_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, is_store;
  logic [7:0]  mask;
  logic [15:0] base_addr;
  logic [2:0]  base_reg;
  logic        busy, done;
  logic [3:0]  xfer_count;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rd, mem_wr, mem_ready;
  logic [2:0]  rf_raddr, rf_waddr;
  logic [15:0] rf_rdata, rf_wdata;
  logic        rf_wen;

  lmsm_engine dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_store(is_store),
    .mask(mask), .base_addr(base_addr), .base_reg(base_reg),
    .busy(busy), .done(done), .xfer_count(xfer_count),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_wen(rf_wen),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Bench-side register file image and memory (data derived from address).
  logic [15:0] rf_img [8];
  logic [15:0] salt;
  assign rf_rdata  = rf_img[rf_raddr];
  assign mem_rdata = mem_addr ^ salt;

  localparam int K_ACC = 0, K_RFW = 1, K_DONE = 2;
  typedef struct {
    int          kind;
    logic [15:0] addr;
    logic [15:0] data;
    int          idx;
    bit          wr;
    int          cnt;
  } exp_t;
  exp_t q[$];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rmode  = 0;
  int wait_cnt = 0;
  bit mon_en = 1'b0;
  bit prev_req = 1'b0;
  logic [15:0] prev_addr, prev_wdata;
  logic        prev_rd, prev_wr;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic pop_expect(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    if (q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL unexpected_event: kind %0d seen with empty scoreboard", kind);
    end else begin
      e = q.pop_front();
      chk("event_kind", e.kind, kind);
      ok = (e.kind == kind);
    end
  endtask

  // Memory ready generator: 0 = always ready, 1 = random, 2 = three wait cycles per access.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_rd || mem_wr) begin
        if (rmode == 0)      mem_ready = 1'b1;
        else if (rmode == 1) mem_ready = 1'($urandom_range(0, 1));
        else begin
          mem_ready = (wait_cnt == 3);
          wait_cnt  = mem_ready ? 0 : wait_cnt + 1;
        end
      end else begin
        wait_cnt  = 0;
        mem_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: compares every observable DUT event against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (reset_n && mon_en) begin
      if (mem_rd || mem_wr) begin
        chk("rd_wr_exclusive", {31'd0, mem_rd & mem_wr}, 32'd0);
        chk("busy_during_access", {31'd0, busy}, 32'd1);
        if (prev_req) begin
          chk("stall_addr", {16'd0, mem_addr}, {16'd0, prev_addr});
          chk("stall_rdwr", {30'd0, mem_rd, mem_wr}, {30'd0, prev_rd, prev_wr});
          chk("stall_wdata", {16'd0, mem_wdata}, {16'd0, prev_wdata});
        end
        if (mem_ready) begin
          pop_expect(K_ACC, e, ok);
          if (ok) begin
            chk("mem_addr", {16'd0, mem_addr}, {16'd0, e.addr});
            chk("mem_dir", {30'd0, mem_wr, mem_rd}, {30'd0, e.wr, ~e.wr});
            if (e.wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.data});
          end
        end
      end else if (prev_req) begin
        n_chk++;
        n_fail++;
        $display("FAIL stall_dropped: request withdrawn before ready");
      end
      if (rf_wen) begin
        pop_expect(K_RFW, e, ok);
        if (ok) begin
          chk("rf_waddr", {29'd0, rf_waddr}, e.idx);
          chk("rf_wdata", {16'd0, rf_wdata}, {16'd0, e.data});
        end
      end
      if (done) begin
        pop_expect(K_DONE, e, ok);
        if (ok) begin
          chk("done_count", {28'd0, xfer_count}, e.cnt);
          chk("done_busy", {31'd0, busy}, 32'd0);
        end
      end
      prev_req   = (mem_rd || mem_wr) && !mem_ready;
      prev_addr  = mem_addr;
      prev_wdata = mem_wdata;
      prev_rd    = mem_rd;
      prev_wr    = mem_wr;
    end
  end

  // Reference model: one access per set bit, lowest first, at consecutive addresses.
  task automatic push_expect(input bit st, input logic [7:0] m, input logic [15:0] b,
                             input logic [2:0] br, output int k);
    exp_t        e;
    logic [15:0] a;
    a = b;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        e = '{kind: K_ACC, addr: a, data: (st ? rf_img[i] : 16'h0), idx: i, wr: st, cnt: 0};
        q.push_back(e);
        if (!st) begin
          e = '{kind: K_RFW, addr: a, data: a ^ salt, idx: i, wr: 1'b0, cnt: 0};
          q.push_back(e);
        end
        a = a + 16'd1;
        k++;
      end
    end
    if (WB_EN) begin
      e = '{kind: K_RFW, addr: 16'h0, data: a, idx: int'(br), wr: 1'b0, cnt: 0};
      q.push_back(e);
    end
    e = '{kind: K_DONE, addr: 16'h0, data: 16'h0, idx: 0, wr: 1'b0, cnt: k};
    q.push_back(e);
  endtask

  task automatic run_op(input bit st, input logic [7:0] m, input logic [15:0] b,
                        input logic [2:0] br, input bit chk_lat, input bit extra_start);
    int k, t0, lat;
    bit got;
    @(posedge clk);
    #1;
    salt     = 16'($urandom);
    wait_cnt = 0;
    push_expect(st, m, b, br, k);
    is_store  = st;
    mask      = m;
    base_addr = b;
    base_reg  = br;
    start     = 1'b1;
    t0        = cyc;
    @(posedge clk);
    #1;
    start     = extra_start;
    is_store  = 1'($urandom);
    mask      = 8'($urandom);
    base_addr = 16'($urandom);
    base_reg  = 3'($urandom);
    @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, {31'd0, ((k != 0) || WB_EN)});
    got = done;
    lat = cyc - t0;
    if (extra_start) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        lat = cyc - t0;
      end
    end
    if (!got) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within bound, mask %0h", m);
    end else if (chk_lat) begin
      chk("done_latency", lat, k + 1 + int'(WB_EN));
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("count_hold", {28'd0, xfer_count}, k);
    chk("scoreboard_drained", q.size(), 0);
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    is_store  = 1'b0;
    mask      = 8'h00;
    base_addr = 16'h0;
    base_reg  = 3'd0;
    salt      = 16'h0;
    for (int i = 0; i < 8; i++) rf_img[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {27'd0, busy, done, mem_rd, mem_wr, rf_wen}, 32'd0);
    chk("reset_count", {28'd0, xfer_count}, 32'd0);
    chk("reset_addr", {16'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    rmode = 0;
    run_op(1'b0, 8'b1010_0101, 16'h0040, 3'd1, 1'b1, 1'b0);
    rmode = 2;
    run_op(1'b1, 8'h81, 16'h0010, 3'd2, 1'b0, 1'b0);
    rmode = 0;
    run_op(1'b0, 8'h00, 16'h1234, 3'd3, 1'b1, 1'b0);
    run_op(1'b1, 8'h00, 16'h4321, 3'd5, 1'b1, 1'b0);
    run_op(1'b0, 8'h03, 16'hFFFF, 3'd0, 1'b1, 1'b0);
    run_op(1'b1, 8'h5A, 16'h2000, 3'd4, 1'b1, 1'b1);
    run_op(1'b0, 8'h80, 16'hFFFE, 3'd7, 1'b1, 1'b1);

    // Reset in the middle of a load; monitor paused since the op never completes.
    mon_en = 1'b0;
    rmode  = 1;
    @(posedge clk);
    #1;
    is_store  = 1'b0;
    mask      = 8'hFF;
    base_addr = 16'h0300;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, busy, done, mem_rd, mem_wr, rf_wen}, 32'd0);
    chk("async_rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("async_rst_count", {28'd0, xfer_count}, 32'd0);
    @(posedge clk);
    #1;
    reset_n  = 1'b1;
    prev_req = 1'b0;
    q.delete();
    mon_en   = 1'b1;
    rmode    = 0;
    run_op(1'b0, 8'h3C, 16'h0500, 3'd6, 1'b1, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rmode = $urandom_range(0, 1);
      run_op(1'($urandom), 8'($urandom), 16'($urandom), 3'($urandom),
             (rmode == 0), 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
